// File: rtl/ram_window_sequencer.sv
// Burst sequencer and window probe for the disparity line-buffer RAM.
// It drives the RAM clock-enable and the left/right pixel addresses in three
// modes: single step, single line, or free run. It tracks the column/row
// position across a frame. It also captures one element of each pixel window
// into hold registers, which the board can read out.
module ram_window_sequencer #(
  parameter int LINE_W  = 640,
  parameter int N_LINES = 480,
  parameter int WIN     = 5,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = $clog2(LINE_W * N_LINES),
  parameter int SEL_W   = $clog2(WIN),
  parameter int DISP_W  = 7,
  localparam int COL_W  = $clog2(LINE_W),
  localparam int ROW_W  = $clog2(N_LINES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_step,
  input  logic                     i_line,
  input  logic                     i_run,
  input  logic                     i_freeze,
  input  logic [DISP_W-1:0]        i_disp,
  input  logic [SEL_W-1:0]         i_sel_row,
  input  logic [SEL_W-1:0]         i_sel_col,
  input  logic [WIN*WIN*PIX_W-1:0] i_win_l,
  input  logic [WIN*WIN*PIX_W-1:0] i_win_r,
  output logic                     o_clken,
  output logic [ADDR_W-1:0]        o_addr_l,
  output logic [ADDR_W-1:0]        o_addr_r,
  output logic [COL_W-1:0]         o_col,
  output logic [ROW_W-1:0]         o_row,
  output logic [PIX_W-1:0]         o_hold_l,
  output logic [PIX_W-1:0]         o_hold_r,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int CMP_W = (COL_W > DISP_W) ? COL_W : DISP_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_RUN} state_t;

  state_t state, state_nxt;
  logic   step_q, step_d, line_q, line_d;
  logic   step_rise, line_rise;
  logic   clken_nxt, clken_d;
  logic   eol;

  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt;
  logic              frame_wrap;
  logic [CMP_W-1:0]  col_ext, disp_ext, off_r;
  logic [PIX_W-1:0]  pick_l, pick_r;

  assign step_rise = step_q & ~step_d;
  assign line_rise = line_q & ~line_d;
  assign eol       = o_clken && (o_col == LAST_COL);

  // Register the keys, then keep a delayed copy of each for rising-edge detection.
  // NOTE: sequential state always uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      step_d <= 1'b0;
      line_q <= 1'b0;
      line_d <= 1'b0;
    end else begin
      step_q <= i_step;
      step_d <= step_q;
      line_q <= i_line;
      line_d <= line_q;
    end
  end

  // FSM state register, plus the registered clock-enable and its one-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      o_clken <= 1'b0;
      clken_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_clken <= clken_nxt;
      clken_d <= o_clken;
    end
  end

  // Next-state logic. Key edges are only honoured in IDLE. Bursts leave only at end of line.
  // NOTE: each combinational block assigns a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_run)          state_nxt = S_RUN;
        else if (line_rise) state_nxt = S_LINE;
      end
      S_LINE:  if (eol)           state_nxt = S_IDLE;
      S_RUN:   if (eol && !i_run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: enable whenever a burst continues, or for one step taken in IDLE.
  always_comb begin
    clken_nxt = (state_nxt != S_IDLE) || ((state == S_IDLE) && step_rise);
    o_busy    = (state != S_IDLE);
  end

  // Position advance on an enable cycle. The row base is stepped by LINE_W, so no multiplier is needed.
  always_comb begin
    col_nxt      = o_col;
    row_nxt      = o_row;
    row_base_nxt = row_base;
    frame_wrap   = 1'b0;
    if (o_clken) begin
      if (o_col == LAST_COL) begin
        col_nxt = '0;
        if (o_row == LAST_ROW) begin
          row_nxt      = '0;
          row_base_nxt = '0;
          frame_wrap   = 1'b1;
        end else begin
          row_nxt      = o_row + 1'b1;
          row_base_nxt = row_base + ADDR_W'(LINE_W);
        end
      end else begin
        col_nxt = o_col + 1'b1;
      end
    end
    col_ext  = CMP_W'(col_nxt);
    disp_ext = CMP_W'(i_disp);
    off_r    = (col_ext >= disp_ext) ? (col_ext - disp_ext) : '0;
  end

  // Position and address registers. Addresses are refreshed every cycle, so a changed offset shows up while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_col        <= '0;
      o_row        <= '0;
      row_base     <= '0;
      o_addr_l     <= '0;
      o_addr_r     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_col        <= col_nxt;
      o_row        <= row_nxt;
      row_base     <= row_base_nxt;
      o_addr_l     <= row_base_nxt + ADDR_W'(col_nxt);
      o_addr_r     <= row_base_nxt + ADDR_W'(off_r);
      o_frame_done <= frame_wrap;
    end
  end

  // Window element mux. A select outside the window yields zero.
  always_comb begin
    pick_l = '0;
    pick_r = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (i_sel_row == SEL_W'(r) && i_sel_col == SEL_W'(c)) begin
          pick_l = i_win_l[(r*WIN+c)*PIX_W +: PIX_W];
          pick_r = i_win_r[(r*WIN+c)*PIX_W +: PIX_W];
        end
      end
    end
  end

  // Capture the selected element in the cycle after an enable, when the RAM output is valid, unless frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hold_l <= '0;
      o_hold_r <= '0;
    end else if (clken_d && !i_freeze) begin
      o_hold_l <= pick_l;
      o_hold_r <= pick_r;
    end
  end

endmodule

// File: tb/tb_ram_window_sequencer.sv
// Self-checking bench for ram_window_sequencer, built with a small frame (16x4).
// Every pixel the sequencer should feed is queued ahead of time from a
// reference position model. A monitor pops one entry for each o_clken cycle
// and compares column, row and both addresses against it.
module tb_ram_window_sequencer;

  localparam int L      = 16;
  localparam int NL     = 4;
  localparam int WIN    = 5;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = $clog2(L * NL);
  localparam int SEL_W  = $clog2(WIN);
  localparam int DISP_W = 7;
  localparam int COL_W  = $clog2(L);
  localparam int ROW_W  = $clog2(NL);

  typedef struct {
    int col;
    int row;
    int addr_l;
    int addr_r;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_step = 1'b0, i_line = 1'b0, i_run = 1'b0, i_freeze = 1'b0;
  logic [DISP_W-1:0] i_disp = '0;
  logic [SEL_W-1:0] i_sel_row = '0, i_sel_col = '0;
  logic [WIN*WIN*PIX_W-1:0] i_win_l, i_win_r;
  logic o_clken, o_busy, o_frame_done;
  logic [ADDR_W-1:0] o_addr_l, o_addr_r;
  logic [COL_W-1:0] o_col;
  logic [ROW_W-1:0] o_row;
  logic [PIX_W-1:0] o_hold_l, o_hold_r;

  int n_cmp = 0;
  int n_err = 0;
  pix_t sb[$];
  int m_col = 0, m_row = 0, m_disp = 0;

  ram_window_sequencer #(
    .LINE_W(L), .N_LINES(NL), .WIN(WIN), .PIX_W(PIX_W),
    .ADDR_W(ADDR_W), .SEL_W(SEL_W), .DISP_W(DISP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_step(i_step), .i_line(i_line), .i_run(i_run), .i_freeze(i_freeze),
    .i_disp(i_disp), .i_sel_row(i_sel_row), .i_sel_col(i_sel_col),
    .i_win_l(i_win_l), .i_win_r(i_win_r),
    .o_clken(o_clken), .o_addr_l(o_addr_l), .o_addr_r(o_addr_r),
    .o_col(o_col), .o_row(o_row), .o_hold_l(o_hold_l), .o_hold_r(o_hold_r),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  // Queue the next n pixels in feed order, with addresses from the reference model.
  function automatic void push_pixels(int n);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.col    = m_col;
      p.row    = m_row;
      p.addr_l = m_row * L + m_col;
      p.addr_r = m_row * L + ((m_col >= m_disp) ? (m_col - m_disp) : 0);
      sb.push_back(p);
      m_col++;
      if (m_col == L) begin
        m_col = 0;
        m_row = (m_row + 1) % NL;
      end
    end
  endfunction

  // Scoreboard monitor: every enable cycle must match the oldest queued pixel.
  always @(negedge clk) begin
    if (rst_n && o_clken) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL clken_unexpected: got clken at col=%0d row=%0d, required no clken", o_col, o_row);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if (int'(o_col) !== e.col || int'(o_row) !== e.row ||
            int'(o_addr_l) !== e.addr_l || int'(o_addr_r) !== e.addr_r) begin
          n_err++;
          $display("FAIL pixel: got col=%0d row=%0d addr_l=%0d addr_r=%0d, required col=%0d row=%0d addr_l=%0d addr_r=%0d",
                   o_col, o_row, o_addr_l, o_addr_r, e.col, e.row, e.addr_l, e.addr_r);
        end
      end
    end
  end

  task automatic pulse_step();
    @(negedge clk); i_step = 1'b1;
    @(negedge clk); i_step = 1'b0;
  endtask

  task automatic pulse_line();
    @(negedge clk); i_line = 1'b1;
    @(negedge clk); i_line = 1'b0;
  endtask

  // Wait (bounded) until every queued pixel has been fed and the sequencer is idle.
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy && !o_clken) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (o_clken !== 1'b0) begin n_err++; $display("FAIL reset_clken: got %0d, required 0", o_clken); end
    n_cmp++; if (o_addr_l !== '0 || o_addr_r !== '0) begin n_err++; $display("FAIL reset_addr: got l=%0d r=%0d, required 0/0", o_addr_l, o_addr_r); end
    n_cmp++; if (o_col !== '0 || o_row !== '0) begin n_err++; $display("FAIL reset_pos: got col=%0d row=%0d, required 0/0", o_col, o_row); end
    n_cmp++; if (o_hold_l !== '0 || o_hold_r !== '0) begin n_err++; $display("FAIL reset_hold: got l=%0d r=%0d, required 0/0", o_hold_l, o_hold_r); end
    n_cmp++; if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%0d fd=%0d, required 0/0", o_busy, o_frame_done); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_step();
    i_sel_row = 3'd2; i_sel_col = 3'd4;
    push_pixels(1);
    pulse_step();
    @(negedge clk);
    n_cmp++; if (o_clken !== 1'b1 || o_busy !== 1'b0) begin n_err++; $display("FAIL step_clken: got clken=%0d busy=%0d, required 1/0", o_clken, o_busy); end
    @(negedge clk);
    n_cmp++; if (o_clken !== 1'b0) begin n_err++; $display("FAIL step_single: got clken=%0d, required 0", o_clken); end
    n_cmp++; if (o_col !== 4'd1 || o_addr_l !== 6'd1) begin n_err++; $display("FAIL step_advance: got col=%0d addr_l=%0d, required 1/1", o_col, o_addr_l); end
    @(negedge clk);
    n_cmp++; if (o_hold_l !== 8'd14 || o_hold_r !== 8'd114) begin n_err++; $display("FAIL step_hold: got l=%0d r=%0d, required 14/114", o_hold_l, o_hold_r); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sel_freeze();
    i_sel_row = 3'd2; i_sel_col = 3'd5;
    push_pixels(1); pulse_step(); repeat (3) @(negedge clk);
    n_cmp++; if (o_hold_l !== 8'd0 || o_hold_r !== 8'd0) begin n_err++; $display("FAIL sel_out_of_range: got l=%0d r=%0d, required 0/0", o_hold_l, o_hold_r); end
    i_sel_col = 3'd4; i_freeze = 1'b1;
    push_pixels(1); pulse_step(); repeat (3) @(negedge clk);
    n_cmp++; if (o_hold_l !== 8'd0 || o_hold_r !== 8'd0) begin n_err++; $display("FAIL freeze_hold: got l=%0d r=%0d, required 0/0", o_hold_l, o_hold_r); end
    i_freeze = 1'b0; i_sel_row = 3'd1; i_sel_col = 3'd3;
    push_pixels(1); pulse_step(); repeat (3) @(negedge clk);
    n_cmp++; if (o_hold_l !== 8'd8 || o_hold_r !== 8'd108) begin n_err++; $display("FAIL unfreeze_hold: got l=%0d r=%0d, required 8/108", o_hold_l, o_hold_r); end
    i_sel_row = 3'd2; i_sel_col = 3'd4;
  endtask

  task automatic test_line_burst();
    // Mid-line start (col 4) finishes the current line only.
    push_pixels(L - m_col);
    pulse_line();
    wait_drain(100);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL line_mid_timeout: got %0d pending, required 0", sb.size()); end
    n_cmp++; if (o_col !== 4'd0 || o_row !== 2'd1 || o_addr_l !== 6'd16 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL line_mid_end: got col=%0d row=%0d addr_l=%0d busy=%0d, required 0/1/16/0", o_col, o_row, o_addr_l, o_busy); end
    // Full line from col 0, with step keys during the burst ignored.
    push_pixels(L);
    pulse_line();
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL line_busy: got %0d, required 1", o_busy); end
    pulse_step();
    pulse_step();
    wait_drain(100);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL line_full_timeout: got %0d pending, required 0", sb.size()); end
    n_cmp++; if (o_col !== 4'd0 || o_row !== 2'd2 || o_addr_l !== 6'd32 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL line_full_end: got col=%0d row=%0d addr_l=%0d busy=%0d, required 0/2/32/0", o_col, o_row, o_addr_l, o_busy); end
  endtask

  task automatic test_line_vs_step();
    push_pixels(L);
    @(negedge clk); i_line = 1'b1; i_step = 1'b1;
    @(negedge clk); i_line = 1'b0; i_step = 1'b0;
    wait_drain(100);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL line_priority_timeout: got %0d pending, required 0", sb.size()); end
    n_cmp++; if (o_col !== 4'd0 || o_row !== 2'd3) begin n_err++; $display("FAIL line_priority_end: got col=%0d row=%0d, required 0/3", o_col, o_row); end
  endtask

  task automatic test_disp();
    m_disp = 5; i_disp = 7'd5;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      push_pixels(1); pulse_step(); repeat (3) @(negedge clk);
      if (i == 3) begin
        n_cmp++; if (o_addr_r !== 6'd48) begin n_err++; $display("FAIL disp_clamp: got addr_r=%0d, required 48", o_addr_r); end
      end
      if (i == 9) begin
        n_cmp++; if (o_addr_r !== 6'd52) begin n_err++; $display("FAIL disp_offset: got addr_r=%0d, required 52", o_addr_r); end
      end
    end
    push_pixels(L - m_col);
    pulse_line();
    wait_drain(100);
    n_cmp++; if (sb.size() != 0 || o_col !== 4'd0 || o_row !== 2'd0 || o_addr_l !== 6'd0) begin
      n_err++; $display("FAIL disp_wrap: got pending=%0d col=%0d row=%0d addr_l=%0d, required 0/0/0/0", sb.size(), o_col, o_row, o_addr_l); end
    m_disp = 0; i_disp = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run();
    int frames = 0;
    bit run_on = 1'b1;
    push_pixels(L * NL + L);
    @(negedge clk); i_run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_frame_done) begin
        frames++;
        n_cmp++; if (o_col !== 4'd0 || o_row !== 2'd0 || o_clken !== 1'b1) begin
          n_err++; $display("FAIL run_frame_pos: got col=%0d row=%0d clken=%0d, required 0/0/1", o_col, o_row, o_clken); end
      end
      if (run_on && frames == 1 && o_clken && o_col == 4'd3 && o_row == 2'd0) begin
        i_run = 1'b0; run_on = 1'b0;
      end
      if (!run_on && sb.size() == 0 && !o_busy) break;
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (frames != 1) begin n_err++; $display("FAIL run_frame_count: got %0d, required 1", frames); end
    n_cmp++; if (sb.size() != 0 || o_busy !== 1'b0 || o_clken !== 1'b0) begin
      n_err++; $display("FAIL run_stop: got pending=%0d busy=%0d clken=%0d, required 0/0/0", sb.size(), o_busy, o_clken); end
    n_cmp++; if (o_col !== 4'd0 || o_row !== 2'd1) begin n_err++; $display("FAIL run_end_pos: got col=%0d row=%0d, required 0/1", o_col, o_row); end
  endtask

  task automatic test_reset_mid_run();
    push_pixels(40);
    @(negedge clk); i_run = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0; i_run = 1'b0;
    sb.delete(); m_col = 0; m_row = 0;
    #1;
    n_cmp++; if (o_clken !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_flags: got clken=%0d busy=%0d fd=%0d, required 0/0/0", o_clken, o_busy, o_frame_done); end
    n_cmp++; if (o_col !== '0 || o_row !== '0 || o_addr_l !== '0 || o_addr_r !== '0) begin
      n_err++; $display("FAIL rst_mid_pos: got col=%0d row=%0d l=%0d r=%0d, required 0", o_col, o_row, o_addr_l, o_addr_r); end
    n_cmp++; if (o_hold_l !== '0 || o_hold_r !== '0) begin n_err++; $display("FAIL rst_mid_hold: got l=%0d r=%0d, required 0/0", o_hold_l, o_hold_r); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_clken !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got clken=%0d busy=%0d, required 0/0", o_clken, o_busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (o_clken !== 1'b0 || o_col !== '0) begin n_err++; $display("FAIL rst_mid_no_resume: got clken=%0d col=%0d, required 0/0", o_clken, o_col); end
  endtask

  initial begin
    for (int k = 0; k < WIN * WIN; k++) begin
      i_win_l[k*PIX_W +: PIX_W] = PIX_W'(k);
      i_win_r[k*PIX_W +: PIX_W] = PIX_W'(k + 100);
    end
    test_reset();
    test_step();
    test_sel_freeze();
    test_line_burst();
    test_line_vs_step();
    test_disp();
    test_run();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_window_sequencer.md
# ram_window_sequencer

Parametrised burst sequencer and window probe for the line-buffer RAM of the disparity pipeline. It drives the buffer's clock-enable and left/right pixel addresses in single-step, single-line or free-run mode, tracks column/row position across a frame, and captures one selected element of the left and right pixel windows into hold registers for board-level inspection (7-segment, SignalTap). It sits between the board keys/switches and the RAM block.

## Interface
- LINE_W, 640, pixels per line
- N_LINES, 480, lines per frame
- WIN, 5, window edge (window is WIN×WIN pixels)
- PIX_W, 8, bits per pixel
- ADDR_W, $clog2(LINE_W*N_LINES), address width
- SEL_W, $clog2(WIN), window row/column select width
- DISP_W, 7, disparity offset width

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_step  in  1  step key, level, already synchronised, active-high
- i_line  in  1  line-burst key, level, synchronised, active-high
- i_run  in  1  free-run enable, level
- i_freeze  in  1  1 = hold registers keep their value
- i_disp  in  DISP_W  right-image column offset
- i_sel_row  in  SEL_W  window row to capture
- i_sel_col  in  SEL_W  window column to capture
- i_win_l  in  WIN*WIN*PIX_W  left window, element (r,c) at bits [(r*WIN+c)*PIX_W +: PIX_W]
- i_win_r  in  WIN*WIN*PIX_W  right window, same packing
- o_clken  out  1  RAM clock-enable / start
- o_addr_l  out  ADDR_W  left pixel address
- o_addr_r  out  ADDR_W  right pixel address
- o_col  out  $clog2(LINE_W)  current column
- o_row  out  $clog2(N_LINES)  current row
- o_hold_l  out  PIX_W  captured left element
- o_hold_r  out  PIX_W  captured right element
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse at frame wrap

## Operation
- Key edges: i_step/i_line registered; rise = key & ~key_d. i_run is level-sensitive.
- States: IDLE, LINE, RUN.
  - IDLE: o_clken=0. In priority order: i_run=1 → RUN; i_line rise → LINE; i_step rise → one o_clken cycle, stay IDLE.
  - LINE: o_clken=1 until the column counter wraps (last cycle has col=LINE_W-1), then IDLE. Starting mid-line finishes the current line only.
  - RUN: o_clken=1 every cycle. When i_run=0, complete the current line, then IDLE. i_run=1 at end of line → continue.
- Key edges outside IDLE are ignored, not queued.
- Position: each o_clken cycle advances col; col wraps LINE_W-1→0 and increments row; row wraps N_LINES-1→0 with o_frame_done pulsed in the cycle after the wrapping clken cycle. Once RUN has reached a frame end, it continues into the next frame.
- o_addr_l = row*LINE_W + col. o_addr_r = row*LINE_W + (col ≥ i_disp ? col − i_disp : 0), clamped, never crossing rows.
- Capture: RAM window output is valid one cycle after an o_clken cycle. On that cycle, when i_freeze=0, o_hold_l/o_hold_r load element (i_sel_row,i_sel_col) of i_win_l/i_win_r. Select index ≥ WIN loads 0.
- All arithmetic unsigned. Address multiply uses constant LINE_W, with no DSP required.

## Timing
- Reset: state IDLE, o_clken=0, o_addr_l=o_addr_r=0, col=row=0, holds=0, o_busy=0, o_frame_done=0, key_d=0.
- o_clken is registered. A rise sampled at edge k gives o_clken=1 from edge k+1.
- Addresses and col/row are registered. During an o_clken cycle, they show the pixel being fed, then update at that cycle's closing edge.
- Hold latency: 2 cycles from the o_clken rise to the new o_hold value.
- LINE from col 0: exactly LINE_W consecutive o_clken cycles.
- Reset asserted mid-burst: immediate return to reset values. No pending burst resumes.
- i_freeze and select inputs are sampled at the capture edge only.

## Test plan
- Reset, one i_step pulse (LINE_W=640) → single o_clken cycle at o_addr_l=0; afterwards col=1, addr_l=1; o_hold_l = element selected from i_win_l two cycles after the step.
- i_line rise at col 0 → exactly 640 o_clken cycles; ends with col=0, row=1, addr_l=640, state IDLE. i_step edges during the burst are ignored.
- i_run=1 with small params (LINE_W=8, N_LINES=4) → 32 clken cycles, then o_frame_done pulse, row=col=0; i_run dropped at col 3 → clken continues through col 7, then stops.
- i_disp=5: at col 3, o_addr_r = row*LINE_W (clamped); at col 9, o_addr_r = row*LINE_W+4.
- i_sel_row=2, i_sel_col=4 with a known window pattern → o_hold_l = byte 14. Select 5 (≥WIN) → 0. With i_freeze=1, the hold is unchanged across a step.
- Simultaneous i_line and i_step rise → LINE taken; rst_n low mid-RUN → all outputs zero, and in the next cycle IDLE is entered with no clken.
